// File: rtl/ifetch_sequencer_if.sv
// Fetch-stage bus bundle: instruction memory address/data, redirect request
// and the IF/ID valid/ready hand-off to decode.
// master: the fetch sequencer. slave: memory/decode side.
interface ifetch_sequencer_if #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 32
);

  logic [ADDR_W-1:0] imem_addr;
  logic [DATA_W-1:0] imem_instr;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_addr;
  logic              id_valid;
  logic              id_ready;
  logic [DATA_W-1:0] id_instr;
  logic [ADDR_W-1:0] id_pc;
  logic [ADDR_W-1:0] id_pc_plus1;

  modport master (
    output imem_addr,
    input  imem_instr,
    input  redirect_valid,
    input  redirect_addr,
    output id_valid,
    input  id_ready,
    output id_instr,
    output id_pc,
    output id_pc_plus1
  );

  modport slave (
    input  imem_addr,
    output imem_instr,
    output redirect_valid,
    output redirect_addr,
    input  id_valid,
    output id_ready,
    input  id_instr,
    input  id_pc,
    input  id_pc_plus1
  );

endinterface

// File: rtl/ifetch_sequencer.sv
// Fetch-stage controller: owns the PC, addresses the combinational instruction
// memory and captures the returned word into the IF/ID register, handing it to
// decode over valid/ready. Supports stall, redirect (flush) and halt-on-opcode.
// Optional performance counters are built when IFETCH_PERF_CNT_EN is defined.
module ifetch_sequencer #(
  parameter int unsigned       ADDR_W      = 5,
  parameter int unsigned       DATA_W      = 32,
  parameter logic [ADDR_W-1:0] RESET_PC    = '0,
  parameter logic [5:0]        HALT_OPCODE = 6'b111111
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  ifetch_sequencer_if.master       bus,
  output logic                     busy,
  output logic                     halted
`ifdef IFETCH_PERF_CNT_EN
  ,
  output logic [15:0]              fetch_count,
  output logic [15:0]              stall_count
`endif
);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StFetch = 2'd1,
    StHalt  = 2'd2
  } state_e;

  localparam logic [ADDR_W-1:0] PcOne = ADDR_W'(1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              id_valid_q, id_valid_d;
  logic [DATA_W-1:0] id_instr_q;
  logic [ADDR_W-1:0] id_pc_q;
  logic [ADDR_W-1:0] id_pc_plus1_q;

  logic       xfer;
  logic       slot_free;
  logic       is_halt_op;
  logic       capture;
  logic       stall;
  logic [5:0] opcode;

  assign xfer       = id_valid_q & bus.id_ready;
  assign slot_free  = ~id_valid_q | xfer;
  assign opcode     = bus.imem_instr[DATA_W-1 -: 6];
  assign is_halt_op = (opcode == HALT_OPCODE);

  // Next-state, PC and IF/ID valid decisions, in redirect > capture > stall order.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    // An accepted word leaves the slot unless something refills it below.
    id_valid_d = id_valid_q & ~xfer;
    capture    = 1'b0;
    stall      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          pc_d    = RESET_PC;
          state_d = StFetch;
        end
      end

      StFetch: begin
        if (bus.redirect_valid) begin
          pc_d       = bus.redirect_addr;
          id_valid_d = 1'b0;
        end else if (slot_free) begin
          capture    = 1'b1;
          id_valid_d = 1'b1;
          // The halt word is delivered, but the PC parks on it.
          if (is_halt_op) begin
            state_d = StHalt;
          end else begin
            pc_d = pc_q + PcOne;
          end
        end else begin
          stall = 1'b1;
        end
      end

      StHalt: begin
        if (bus.redirect_valid) begin
          pc_d       = bus.redirect_addr;
          id_valid_d = 1'b0;
          state_d    = StFetch;
        end else if (start) begin
          pc_d       = RESET_PC;
          id_valid_d = 1'b0;
          state_d    = StFetch;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State, PC and IF/ID valid registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      pc_q       <= RESET_PC;
      id_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      id_valid_q <= id_valid_d;
    end
  end

  // IF/ID payload: only written on capture, so stalls and flushes hold it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      id_instr_q    <= '0;
      id_pc_q       <= '0;
      id_pc_plus1_q <= '0;
    end else if (capture) begin
      id_instr_q    <= bus.imem_instr;
      id_pc_q       <= pc_q;
      id_pc_plus1_q <= pc_q + PcOne;
    end
  end

  assign bus.imem_addr   = pc_q;
  assign bus.id_valid    = id_valid_q;
  assign bus.id_instr    = id_instr_q;
  assign bus.id_pc       = id_pc_q;
  assign bus.id_pc_plus1 = id_pc_plus1_q;
  assign busy            = (state_q == StFetch);
  assign halted          = (state_q == StHalt);

`ifdef IFETCH_PERF_CNT_EN
  logic [15:0] fetch_cnt_q;
  logic [15:0] stall_cnt_q;
  logic        cnt_clr;

  // start only has meaning outside FETCH, so only there does it clear the counters.
  assign cnt_clr = start & (state_q != StFetch);

  // Saturating capture and stall counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else if (cnt_clr) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (capture && (fetch_cnt_q != 16'hFFFF)) begin
        fetch_cnt_q <= fetch_cnt_q + 16'd1;
      end
      if (stall && (stall_cnt_q != 16'hFFFF)) begin
        stall_cnt_q <= stall_cnt_q + 16'd1;
      end
    end
  end

  assign fetch_count = fetch_cnt_q;
  assign stall_count = stall_cnt_q;
`endif

endmodule

// File: tb/tb_ifetch_sequencer.sv
// Bench for ifetch_sequencer. A stream-level reference model predicts the
// sequence of words decode must accept: contiguous addresses from each start or
// redirect target, ending after a halt word. Directed cycle checks cover
// latency, stall, redirect, halt and async reset; a random phase follows.
module tb_ifetch_sequencer;

  localparam int unsigned AW     = 5;
  localparam int unsigned DW     = 32;
  localparam logic [5:0]  HaltOp = 6'b111111;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic busy;
  logic halted;
`ifdef IFETCH_PERF_CNT_EN
  logic [15:0] fetch_count;
  logic [15:0] stall_count;
`endif

  logic [DW-1:0] mem [32];
  int errors = 0;
  int checks = 0;

  ifetch_sequencer_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  ifetch_sequencer #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .bus    (bus),
    .busy   (busy),
`ifdef IFETCH_PERF_CNT_EN
    .fetch_count (fetch_count),
    .stall_count (stall_count),
`endif
    .halted (halted)
  );

  always #5 clk = ~clk;

  assign bus.imem_instr = mem[bus.imem_addr];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference stream model ----------------
  typedef struct {
    int            gen;
    logic [AW-1:0] pc;
    logic [DW-1:0] instr;
  } exp_t;

  exp_t          exp_q[$];
  int            cur_gen      = 0;
  bit            newgen_cycle = 1'b0;
  logic [AW-1:0] seg_addr     = '0;
  bit            seg_done     = 1'b1;

  function automatic int pending_cur();
    int n = 0;
    foreach (exp_q[i]) if (exp_q[i].gen == cur_gen) n++;
    return n;
  endfunction

  function automatic bit model_halted();
    return seg_done && (pending_cur() == 0);
  endfunction

  task automatic refill();
    while (!seg_done && pending_cur() < 8) begin
      exp_t e;
      logic [DW-1:0] w;
      w       = mem[seg_addr];
      e.gen   = cur_gen;
      e.pc    = seg_addr;
      e.instr = w;
      exp_q.push_back(e);
      if (w[31:26] == HaltOp) seg_done = 1'b1;
      seg_addr = seg_addr + 5'd1;
    end
  endtask

  // A new stream begins; words of older streams still queued are flushed.
  task automatic seg_begin(input logic [AW-1:0] addr);
    cur_gen++;
    newgen_cycle = 1'b1;
    seg_addr     = addr;
    seg_done     = 1'b0;
    refill();
  endtask

  task automatic model_reset();
    exp_q.delete();
    cur_gen++;
    seg_done = 1'b1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    newgen_cycle = 1'b0;
    refill();
  endtask

  // ---------------- monitor ----------------
  int            mon_acc;
  exp_t          mon_e;
  logic [AW-1:0] mon_p1;

  always @(negedge clk) begin
    if (!rst && bus.id_valid && bus.id_ready) begin
      // A transfer in a restart cycle still belongs to the previous stream.
      mon_acc = cur_gen - (newgen_cycle ? 1 : 0);
      while (exp_q.size() > 0 && exp_q[0].gen < mon_acc) void'(exp_q.pop_front());
      if (exp_q.size() == 0 || exp_q[0].gen != mon_acc) begin
        checks++;
        errors++;
        $display("FAIL xfer_unexpected: got pc=%0d instr=%h, required no transfer at %0t",
                 bus.id_pc, bus.id_instr, $time);
      end else begin
        mon_e  = exp_q.pop_front();
        mon_p1 = mon_e.pc + 5'd1;
        chk("xfer_pc", 32'(bus.id_pc), 32'(mon_e.pc));
        chk("xfer_instr", bus.id_instr, mon_e.instr);
        chk("xfer_pc_plus1", 32'(bus.id_pc_plus1), 32'(mon_p1));
      end
    end
  end

  // ---------------- stimulus ----------------
  bit            redir;
  bit            stt;
  bit            hm;
  logic [AW-1:0] raddr;

  initial begin
    rst                = 1'b1;
    start              = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_addr  = '0;
    bus.id_ready       = 1'b0;
    for (int k = 0; k < 32; k++) mem[k] = 32'(k);

    #2;
    chk("rst_id_valid", 32'(bus.id_valid), 32'd0);
    chk("rst_id_instr", bus.id_instr, 32'd0);
    chk("rst_id_pc", 32'(bus.id_pc), 32'd0);
    chk("rst_id_pc_plus1", 32'(bus.id_pc_plus1), 32'd0);
    chk("rst_imem_addr", 32'(bus.imem_addr), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
`ifdef IFETCH_PERF_CNT_EN
    chk("rst_fetch_count", 32'(fetch_count), 32'd0);
    chk("rst_stall_count", 32'(stall_count), 32'd0);
`endif
    tick();
    tick();
    rst = 1'b0;

    // Redirect is ignored in IDLE.
    bus.redirect_valid = 1'b1;
    bus.redirect_addr  = 5'd7;
    tick();
    bus.redirect_valid = 1'b0;
    chk("idle_redirect_addr", 32'(bus.imem_addr), 32'd0);
    chk("idle_redirect_busy", 32'(busy), 32'd0);

    // Sequential fetch from 0 with wrap.
    bus.id_ready = 1'b1;
    start        = 1'b1;
    seg_begin(5'd0);
    tick();
    start = 1'b0;
    chk("start_busy", 32'(busy), 32'd1);
    chk("start_no_word_yet", 32'(bus.id_valid), 32'd0);
    chk("start_imem_addr", 32'(bus.imem_addr), 32'd0);
    tick();
    chk("first_valid", 32'(bus.id_valid), 32'd1);
    chk("first_pc", 32'(bus.id_pc), 32'd0);
    for (int k = 1; k <= 37; k++) begin
      tick();
      chk("seq_valid", 32'(bus.id_valid), 32'd1);
      chk("seq_pc", 32'(bus.id_pc), 32'(k % 32));
    end

    // Stall at id_pc=5.
    chk("stall_pre_addr", 32'(bus.imem_addr), 32'd6);
    bus.id_ready = 1'b0;
    repeat (3) begin
      tick();
      chk("stall_pc", 32'(bus.id_pc), 32'd5);
      chk("stall_instr", bus.id_instr, 32'd5);
      chk("stall_addr", 32'(bus.imem_addr), 32'd6);
      chk("stall_valid", 32'(bus.id_valid), 32'd1);
    end
    bus.id_ready = 1'b1;
    tick();
    chk("stall_release_pc", 32'(bus.id_pc), 32'd6);

    // Redirect to 20 while id_pc=3.
    repeat (29) tick();
    chk("redir_pre_pc", 32'(bus.id_pc), 32'd3);
    bus.redirect_valid = 1'b1;
    bus.redirect_addr  = 5'd20;
    seg_begin(5'd20);
    tick();
    bus.redirect_valid = 1'b0;
    chk("redir_flush_valid", 32'(bus.id_valid), 32'd0);
    chk("redir_imem_addr", 32'(bus.imem_addr), 32'd20);
    tick();
    chk("redir_first_valid", 32'(bus.id_valid), 32'd1);
    chk("redir_first_pc", 32'(bus.id_pc), 32'd20);
    tick();
    chk("redir_second_pc", 32'(bus.id_pc), 32'd21);

    // Halt word at 9, reached by redirecting to 7.
    mem[9]             = 32'hFC00_0000;
    bus.redirect_valid = 1'b1;
    bus.redirect_addr  = 5'd7;
    seg_begin(5'd7);
    tick();
    bus.redirect_valid = 1'b0;
    repeat (3) tick();
    chk("halt_word_pc", 32'(bus.id_pc), 32'd9);
    chk("halt_word_instr", bus.id_instr, 32'hFC00_0000);
    chk("halt_word_valid", 32'(bus.id_valid), 32'd1);
    tick();
    chk("halt_halted", 32'(halted), 32'd1);
    chk("halt_busy", 32'(busy), 32'd0);
    chk("halt_valid", 32'(bus.id_valid), 32'd0);
    chk("halt_imem_addr", 32'(bus.imem_addr), 32'd9);
    tick();
    chk("halt_hold_addr", 32'(bus.imem_addr), 32'd9);
    chk("halt_hold_halted", 32'(halted), 32'd1);

    // Restart from HALT with start.
    start = 1'b1;
    seg_begin(5'd0);
    tick();
    start = 1'b0;
    chk("restart_busy", 32'(busy), 32'd1);
    chk("restart_halted", 32'(halted), 32'd0);
    chk("restart_imem_addr", 32'(bus.imem_addr), 32'd0);
    tick();
    chk("restart_pc", 32'(bus.id_pc), 32'd0);
    repeat (10) tick();
    chk("rehalt_halted", 32'(halted), 32'd1);

    // Redirect beats start in HALT.
    start              = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_addr  = 5'd12;
    seg_begin(5'd12);
    tick();
    start              = 1'b0;
    bus.redirect_valid = 1'b0;
    chk("prio_imem_addr", 32'(bus.imem_addr), 32'd12);
    tick();
    chk("prio_pc", 32'(bus.id_pc), 32'd12);

    // start is ignored in FETCH.
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("fetch_start_ignored_pc", 32'(bus.id_pc), 32'd13);
    chk("fetch_start_ignored_busy", 32'(busy), 32'd1);

    // Async reset in the middle of a stall, between clock edges.
    bus.id_ready = 1'b0;
    tick();
    chk("areset_pre_valid", 32'(bus.id_valid), 32'd1);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    chk("areset_valid", 32'(bus.id_valid), 32'd0);
    chk("areset_imem_addr", 32'(bus.imem_addr), 32'd0);
    chk("areset_busy", 32'(busy), 32'd0);
    chk("areset_halted", 32'(halted), 32'd0);
    chk("areset_id_pc", 32'(bus.id_pc), 32'd0);
`ifdef IFETCH_PERF_CNT_EN
    chk("areset_fetch_count", 32'(fetch_count), 32'd0);
    chk("areset_stall_count", 32'(stall_count), 32'd0);
`endif
    tick();
    rst = 1'b0;

    // Random phase over a random program with sparse halt words.
    for (int k = 0; k < 32; k++) begin
      logic [31:0] w;
      w = $urandom();
      if ($urandom_range(0, 9) == 0) w[31:26] = HaltOp;
      else if (w[31:26] == HaltOp) w[31] = 1'b0;
      mem[k] = w;
    end
    bus.id_ready = 1'b1;
    start        = 1'b1;
    seg_begin(5'd0);
    tick();
    start = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      hm    = model_halted();
      redir = ($urandom_range(0, 99) < 4);
      raddr = 5'($urandom_range(0, 31));
      stt   = 1'b0;
      if (hm) stt = ($urandom_range(0, 3) == 0);
      else if (!seg_done) stt = ($urandom_range(0, 99) < 3);
      bus.id_ready       = ($urandom_range(0, 99) < 75);
      bus.redirect_valid = redir;
      bus.redirect_addr  = raddr;
      start              = stt;
      if (redir) seg_begin(raddr);
      else if (stt && hm) seg_begin(5'd0);
      tick();
    end
    bus.redirect_valid = 1'b0;
    start              = 1'b0;
    bus.id_ready       = 1'b1;
    repeat (4) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
